// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction field positions and default widths.
package fetch_unit_pkg;

   localparam int PC_W_DEF    = 16;
   localparam int INSTR_W_DEF = 32;

   localparam int FIELD_W    = 4;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 28;
   localparam int MM_MSB     = 27;
   localparam int MM_LSB     = 24;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_e;

   // Load requests into the PC register, listed highest priority first.
   typedef struct packed {
      logic rst;
      logic branch;
      logic inc;
   } pc_ctrl_t;

   function automatic logic is_busy(input fetch_state_e s);
      return (s == ST_REQ) || (s == ST_WAIT);
   endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: soft reset, branch target (absolute or pc-relative) and
// post-fetch increment, all modulo 2^PC_W.
module pc_reg
   import fetch_unit_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_f,
   input  pc_ctrl_t        ctrl,
   input  logic            br_sel,
   input  logic [PC_W-1:0] imm,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] target;
   logic [PC_W-1:0] pc_next;

   // Sums are PC_W wide, so overflow wraps naturally (0xFFFF + 1 = 0x0000).
   always_comb begin
      target = br_sel ? imm : pc + imm;
   end

   // NOTE: default assignment first so every path drives pc_next; no latch.
   always_comb begin
      pc_next = pc;
      if (ctrl.rst)
         pc_next = RESET_PC;
      else if (ctrl.branch)
         pc_next = target;
      else if (ctrl.inc)
         pc_next = pc + PC_W'(1);
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_f)
         pc <= RESET_PC;
      else
         pc <= pc_next;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: three-state request/wait FSM, instruction register
// and the memory handshake, driving the pc_reg sub-module.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_f,
   input  logic               pc_write,
   input  logic               pc_sel,
   input  logic               br_sel,
   input  logic               pc_rst,
   input  logic [PC_W-1:0]    imm,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic [PC_W-1:0]    mem_addr,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] ir,
   output logic [FIELD_W-1:0] opcode,
   output logic [FIELD_W-1:0] mm,
   output logic               ir_valid,
   output logic               fetch_busy
);

   fetch_state_e    state;
   fetch_state_e    state_next;
   logic [PC_W-1:0] pc;
   logic            fetch_done;
   pc_ctrl_t        pc_ctrl;

   // A branch or soft reset in the completing cycle aborts the fetch, so the
   // returned word is dropped and the PC does not advance.
   assign fetch_done = (state == ST_WAIT) && mem_ready && !pc_sel && !pc_rst;

   assign pc_ctrl = '{rst: pc_rst, branch: pc_sel, inc: fetch_done};

   pc_reg #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk    (clk),
      .rst_f  (rst_f),
      .ctrl   (pc_ctrl),
      .br_sel (br_sel),
      .imm    (imm),
      .pc     (pc)
   );

   always_ff @(posedge clk) begin
      if (!rst_f)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (pc_rst || pc_sel) begin
         state_next = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: if (pc_write)  state_next = ST_REQ;
            ST_REQ:                 state_next = ST_WAIT;
            ST_WAIT: if (mem_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_req    = is_busy(state);
      fetch_busy = is_busy(state);
      mem_addr   = pc;
   end

   // NOTE: ir is a single control register, so it is reset; only wide storage
   // arrays would be left unreset.
   always_ff @(posedge clk) begin
      if (!rst_f) begin
         ir       <= '0;
         ir_valid <= 1'b0;
      end else begin
         ir_valid <= fetch_done;
         if (pc_rst)
            ir <= '0;
         else if (fetch_done)
            ir <= mem_rdata;
      end
   end

   assign pc_out = pc;
   assign opcode = ir[OPCODE_MSB:OPCODE_LSB];
   assign mm     = ir[MM_MSB:MM_LSB];

endmodule
